// File: rtl/i2c_seq_master.sv
// i2c_seq_master: Wishbone sequencer driving the I2C register file for single-byte transfers.
// Optional watchdog (poll timeout and missing-ack abort) enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_seq_master #(
  parameter logic [15:0] CLK_DIV        = 16'd250,
  parameter int          POLL_GAP       = 8,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_timeout,
  output logic [5:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_LO, S_CFG_HI, S_TX, S_CTRL,
    S_POLL, S_GAP, S_RX, S_CLR, S_RESP
  } state_t;

  localparam logic [5:0]  A_CTRL   = 6'h00;
  localparam logic [5:0]  A_STATUS = 6'h04;
  localparam logic [5:0]  A_TX     = 6'h08;
  localparam logic [5:0]  A_RX     = 6'h0C;
  localparam logic [5:0]  A_DIV_LO = 6'h10;
  localparam logic [5:0]  A_DIV_HI = 6'h14;
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  if (POLL_GAP < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("i2c_seq_master: POLL_GAP and TIMEOUT_CYCLES must be >= 1");
  end

  state_t      st, nxt;
  logic        go;
  logic [1:0]  ph;
  logic [15:0] gap_cnt;
  logic        cfg_done;
  logic        rw_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rd_q;
  logic [7:0]  rx_q;
  logic        nack_q;
  logic        wd_hit;
  logic        ack_hit;
  logic        poll_ok;
  logic        cur_rw;
  logic [7:0]  cur_wd;
  logic        nxt_bus;
  logic        nxt_we;
  logic [5:0]  nxt_adr;
  logic [7:0]  nxt_dat;

  assign poll_ok = !rd_q[0] && rd_q[1];
  assign cur_rw  = (st == S_IDLE) ? cmd_rw : rw_q;
  assign cur_wd  = (st == S_IDLE) ? cmd_wdata : wdata_q;

  // ph: 0 = strobe cycle, 1 = waiting for ack, 2 = turnaround with cyc low
  always_comb begin
    go  = 1'b0;
    nxt = st;
    unique case (st)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          go  = 1'b1;
          nxt = !cfg_done ? S_CFG_LO : (cmd_rw ? S_CTRL : S_TX);
        end
      end
      S_GAP: begin
        if (wd_hit) begin
          go  = 1'b1;
          nxt = S_CLR;
        end else if (gap_cnt == GAP_LAST) begin
          go  = 1'b1;
          nxt = S_POLL;
        end
      end
      S_RESP: begin
        go  = 1'b1;
        nxt = S_IDLE;
      end
      default: begin
        if (ack_hit) begin
          go  = 1'b1;
          nxt = S_RESP;
        end else if (ph == 2'd2) begin
          go = 1'b1;
          unique case (st)
            S_CFG_LO: nxt = S_CFG_HI;
            S_CFG_HI: nxt = rw_q ? S_CTRL : S_TX;
            S_TX:     nxt = S_CTRL;
            S_CTRL:   nxt = S_POLL;
            S_POLL: begin
              if (poll_ok)
                nxt = (rw_q && !rd_q[2]) ? S_RX : S_CLR;
              else
                nxt = wd_hit ? S_CLR : S_GAP;
            end
            S_RX:     nxt = S_CLR;
            default:  nxt = S_RESP;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    nxt_bus = 1'b1;
    nxt_we  = 1'b1;
    nxt_adr = A_CTRL;
    nxt_dat = 8'h00;
    unique case (nxt)
      S_CFG_LO: begin
        nxt_adr = A_DIV_LO;
        nxt_dat = CLK_DIV[7:0];
      end
      S_CFG_HI: begin
        nxt_adr = A_DIV_HI;
        nxt_dat = CLK_DIV[15:8];
      end
      S_TX: begin
        nxt_adr = A_TX;
        nxt_dat = cur_wd;
      end
      S_CTRL: nxt_dat = {6'b0, cur_rw, 1'b1};
      S_POLL: begin
        nxt_we  = 1'b0;
        nxt_adr = A_STATUS;
      end
      S_RX: begin
        nxt_we  = 1'b0;
        nxt_adr = A_RX;
      end
      S_CLR: nxt_dat = 8'h00;
      default: begin
        nxt_bus = 1'b0;
        nxt_we  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      ph        <= 2'd0;
      gap_cnt   <= '0;
      cfg_done  <= 1'b0;
      rw_q      <= 1'b0;
      wdata_q   <= 8'h00;
      rd_q      <= 8'h00;
      rx_q      <= 8'h00;
      nack_q    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= 6'h00;
      wb_dat_o  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      cmd_ready <= ((go ? nxt : st) == S_IDLE);
      if (go) begin
        st       <= nxt;
        ph       <= 2'd0;
        gap_cnt  <= '0;
        wb_cyc_o <= nxt_bus;
        wb_stb_o <= nxt_bus;
        wb_we_o  <= nxt_we;
        wb_adr_o <= nxt_adr;
        wb_dat_o <= nxt_dat;
        if (st == S_IDLE) begin
          rw_q    <= cmd_rw;
          wdata_q <= cmd_wdata;
          rx_q    <= 8'h00;
          nack_q  <= 1'b0;
        end
        if (st == S_CFG_HI)
          cfg_done <= 1'b1;
        if (st == S_POLL && poll_ok)
          nack_q <= rd_q[2];
        if (st == S_RX)
          rx_q <= rd_q;
        if (nxt == S_RESP) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= rx_q;
          rsp_nack  <= nack_q;
        end
      end else if (st == S_GAP) begin
        gap_cnt <= gap_cnt + 16'd1;
      end else if (ph == 2'd0 && wb_stb_o) begin
        wb_stb_o <= 1'b0;
        ph       <= 2'd1;
      end else if (ph == 2'd1 && wb_ack_i) begin
        wb_cyc_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_adr_o <= 6'h00;
        wb_dat_o <= 8'h00;
        rd_q     <= wb_dat_i;
        ph       <= 2'd2;
      end
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic [3:0]  ack_cnt;
  logic        to_q;
  logic        wd_abort;

  assign wd_hit   = wd_cnt >= 32'(TIMEOUT_CYCLES - 1);
  assign ack_hit  = (ph == 2'd1) && wb_cyc_o && !wb_ack_i && (ack_cnt == 4'd15);
  // only the watchdog can send GAP, or an unfinished POLL, straight to CLR
  assign wd_abort = go && (nxt == S_CLR) &&
                    ((st == S_GAP) || (st == S_POLL && !poll_ok));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      ack_cnt     <= '0;
      to_q        <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      wd_cnt  <= (st == S_POLL || st == S_GAP) ? wd_cnt + 32'd1 : '0;
      ack_cnt <= (ph == 2'd1 && wb_cyc_o) ? ack_cnt + 4'd1 : '0;
      if (go && st == S_IDLE)
        to_q <= 1'b0;
      else if (wd_abort)
        to_q <= 1'b1;
      if (go && nxt == S_RESP)
        rsp_timeout <= to_q | ack_hit;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign ack_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule
